// File: rtl/fill_burst_writer.sv
// Line-fill FIFO that drains each {addr, line} entry as an AXI INCR write burst.
// Optional macro FILL_BURST_ERRCNT_EN adds a saturating error-response counter (err_cnt_o).
module fill_burst_writer #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BEATS        = 4,
  parameter int unsigned OFFSET_WIDTH = 5,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2,
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned ID           = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               afull_o,
  input  logic                               wren_i,
  input  logic [ADDR_WIDTH+BEATS*DATA_WIDTH-1:0] data_i,
  output logic                               idle_o,
  output logic [ID_WIDTH-1:0]                awid_o,
  output logic [ADDR_WIDTH-1:0]              awaddr_o,
  output logic [3:0]                         awlen_o,
  output logic [2:0]                         awsize_o,
  output logic [1:0]                         awburst_o,
  output logic                               awvalid_o,
  input  logic                               awready_i,
  output logic [ID_WIDTH-1:0]                wid_o,
  output logic [DATA_WIDTH-1:0]              wdata_o,
  output logic [DATA_WIDTH/8-1:0]            wstrb_o,
  output logic                               wlast_o,
  output logic                               wvalid_o,
  input  logic                               wready_i,
  input  logic [ID_WIDTH-1:0]                bid_i,
  input  logic [1:0]                         bresp_i,
  input  logic                               bvalid_i,
  output logic                               bready_o,
`ifdef FILL_BURST_ERRCNT_EN
  output logic [7:0]                         err_cnt_o,
`endif
  output logic                               err_o
);

  localparam int unsigned LINE_W = BEATS * DATA_WIDTH;
  localparam int unsigned ENT_W  = ADDR_WIDTH + LINE_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OUT_W  = 4;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [OUT_W-1:0]      outst, outst_nxt;
  state_t                state;
  logic                  aw_done, w_done;
  logic [BEAT_W-1:0]     beat, nxt_beat;
  logic [LINE_W-1:0]     stg_line;
  logic [ENT_W-1:0]      head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LINE_W-1:0]     head_line;
  logic                  aw_hs, w_hs, b_acc, load, done, push, pop, idle_nxt;
  logic                  unused_bits;

  assign awid_o    = ID_WIDTH'(ID);
  assign wid_o     = ID_WIDTH'(ID);
  assign awlen_o   = 4'(BEATS - 1);
  assign awsize_o  = 3'($clog2(STRB_W));
  assign awburst_o = 2'b01;
  assign wstrb_o   = '1;

  assign head      = mem[rd_ptr];
  assign head_addr = head[ENT_W-1:LINE_W];
  assign head_line = head[LINE_W-1:0];
  assign nxt_beat  = beat + BEAT_W'(1);

  assign unused_bits = ^{bid_i, head_addr[OFFSET_WIDTH-1:0]};

  // Handshakes, FIFO/credit bookkeeping and next-cycle idle
  always_comb begin
    aw_hs     = awvalid_o & awready_i;
    w_hs      = wvalid_o & wready_i;
    b_acc     = bvalid_i & bready_o;
    load      = (state == S_IDLE) && (count != '0) && (outst < OUT_W'(MAX_OUTST));
    done      = (state == S_SEND) && (aw_done || aw_hs) && (w_done || (w_hs && wlast_o));
    pop       = done;
    push      = wren_i && ((count != CNT_W'(DEPTH)) || pop);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    outst_nxt = outst;
    if (aw_hs && !b_acc) begin
      outst_nxt = outst + OUT_W'(1);
    end else if (!aw_hs && b_acc) begin
      outst_nxt = outst - OUT_W'(1);
    end
    idle_nxt  = (count_nxt == '0) && (outst_nxt == '0) &&
                (done || ((state == S_IDLE) && !load));
  end

  // Entry storage; the head stays resident until its burst completes
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      outst     <= '0;
      state     <= S_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat      <= '0;
      stg_line  <= '0;
      awaddr_o  <= '0;
      awvalid_o <= 1'b0;
      wdata_o   <= '0;
      wlast_o   <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
      afull_o   <= 1'b0;
      idle_o    <= 1'b1;
      err_o     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt;
      outst    <= outst_nxt;
      bready_o <= (outst_nxt != '0);
      afull_o  <= (CNT_W'(DEPTH) - count_nxt) <= CNT_W'(AFULL_MARGIN);
      idle_o   <= idle_nxt;
      if (b_acc && (bresp_i != 2'b00)) err_o <= 1'b1;

      case (state)
        S_IDLE: begin
          if (load) begin
            state     <= S_SEND;
            awaddr_o  <= {head_addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
            awvalid_o <= 1'b1;
            aw_done   <= 1'b0;
            stg_line  <= head_line;
            wdata_o   <= head_line[DATA_WIDTH-1:0];
            wlast_o   <= (BEATS == 1);
            wvalid_o  <= 1'b1;
            w_done    <= 1'b0;
            beat      <= '0;
          end
        end
        S_SEND: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          // W beats advance independently of the AW handshake
          if (w_hs) begin
            if (wlast_o) begin
              wvalid_o <= 1'b0;
              wlast_o  <= 1'b0;
              w_done   <= 1'b1;
            end else begin
              beat    <= nxt_beat;
              wdata_o <= stg_line[nxt_beat*DATA_WIDTH +: DATA_WIDTH];
              wlast_o <= (nxt_beat == BEAT_W'(BEATS - 1));
            end
          end
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FILL_BURST_ERRCNT_EN
  // Saturating count of non-OKAY responses
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_o <= '0;
    end else if (b_acc && (bresp_i != 2'b00) && (err_cnt_o != 8'hFF)) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fill_burst_writer.sv
// Randomized self-checking bench for fill_burst_writer against a queue-based model.
module tb_fill_burst_writer;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int BEATS = 4;
  localparam int LW    = BEATS * DW;
  localparam int OFF   = 5;
  localparam int DEPTH = 8;
  localparam int MARG  = 2;
  localparam int MAXO  = 4;
  localparam int IDW   = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } ent_t;

  logic             clk, rst, wren_i, awready_i, wready_i, bvalid_i;
  logic [AW+LW-1:0] data_i;
  logic [IDW-1:0]   bid_i;
  logic [1:0]       bresp_i;
  logic             afull_o, idle_o, awvalid_o, wlast_o, wvalid_o, bready_o, err_o;
  logic [IDW-1:0]   awid_o, wid_o;
  logic [AW-1:0]    awaddr_o;
  logic [3:0]       awlen_o;
  logic [2:0]       awsize_o;
  logic [1:0]       awburst_o;
  logic [DW-1:0]    wdata_o;
  logic [DW/8-1:0]  wstrb_o;
`ifdef FILL_BURST_ERRCNT_EN
  logic [7:0]       err_cnt_o;
`endif

  fill_burst_writer dut (
    .clk(clk), .rst(rst), .afull_o(afull_o), .wren_i(wren_i), .data_i(data_i),
    .idle_o(idle_o), .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .awvalid_o(awvalid_o),
    .awready_i(awready_i), .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .bid_i(bid_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
`ifdef FILL_BURST_ERRCNT_EN
    .err_cnt_o(err_cnt_o),
`endif
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  ent_t q[$];
  logic [DW-1:0] w_hist[$];
  int  m_outst, m_errcnt, m_beat;
  bit  m_err, m_aw_seen, synced;
  int  aw_hs_cnt, w_hs_cnt, wlast_cnt, pop_cnt, push_cnt, drop_cnt;
  logic [AW-1:0] last_awaddr;
  bit  rdy_rand, b_rand, b_err_rand;
  bit  prev_wstall, prev_awstall;
  logic [DW-1:0] prev_wdata;
  logic [AW-1:0] prev_awaddr;

  // Reference model: compares registered outputs, then advances on observed handshakes
  always @(negedge clk) begin
    bit b_acc;
    bit pop_now;
    logic [DW-1:0] exp_d;
    if (synced) begin
      checks++; if (idle_o !== (q.size() == 0 && m_outst == 0)) begin errors++;
        $display("FAIL idle_o got %b exp %b t=%0t", idle_o, (q.size() == 0 && m_outst == 0), $time); end
      checks++; if (bready_o !== (m_outst != 0)) begin errors++;
        $display("FAIL bready_o got %b exp %b t=%0t", bready_o, (m_outst != 0), $time); end
      checks++; if (afull_o !== ((DEPTH - q.size()) <= MARG)) begin errors++;
        $display("FAIL afull_o got %b exp %b (entries %0d) t=%0t", afull_o, ((DEPTH - q.size()) <= MARG), q.size(), $time); end
      checks++; if (err_o !== m_err) begin errors++;
        $display("FAIL err_o got %b exp %b t=%0t", err_o, m_err, $time); end
`ifdef FILL_BURST_ERRCNT_EN
      checks++; if (err_cnt_o !== 8'((m_errcnt > 255) ? 255 : m_errcnt)) begin errors++;
        $display("FAIL err_cnt_o got %0d exp %0d t=%0t", err_cnt_o, m_errcnt, $time); end
`endif
      if (awvalid_o === 1'b1) begin
        checks++;
        if (awlen_o !== 4'd3 || awsize_o !== 3'd3 || awburst_o !== 2'b01 || awid_o !== 4'd0 || m_outst >= MAXO) begin
          errors++;
          $display("FAIL aw_attr len=%0d size=%0d burst=%0d id=%0d outst=%0d t=%0t", awlen_o, awsize_o, awburst_o, awid_o, m_outst, $time);
        end
      end
      if (wvalid_o === 1'b1) begin
        checks++; if (wstrb_o !== 8'hFF || wid_o !== 4'd0) begin errors++;
          $display("FAIL w_attr strb=%h id=%0d t=%0t", wstrb_o, wid_o, $time); end
      end
      if (prev_wstall) begin
        checks++; if (wvalid_o !== 1'b1 || wdata_o !== prev_wdata) begin errors++;
          $display("FAIL w_hold wvalid=%b wdata=%h exp %h t=%0t", wvalid_o, wdata_o, prev_wdata, $time); end
      end
      if (prev_awstall) begin
        checks++; if (awvalid_o !== 1'b1 || awaddr_o !== prev_awaddr) begin errors++;
          $display("FAIL aw_hold awvalid=%b awaddr=%h exp %h t=%0t", awvalid_o, awaddr_o, prev_awaddr, $time); end
      end
    end
    prev_wstall  = (wvalid_o === 1'b1) && (wready_i !== 1'b1) && !rst;
    prev_wdata   = wdata_o;
    prev_awstall = (awvalid_o === 1'b1) && (awready_i !== 1'b1) && !rst;
    prev_awaddr  = awaddr_o;

    if (rst) begin
      q.delete();
      m_outst = 0; m_err = 0; m_errcnt = 0; m_beat = 0; m_aw_seen = 0;
      synced = 1;
    end else if (synced) begin
      b_acc = bvalid_i && (m_outst != 0);
      if (b_acc) begin
        m_outst--;
        if (bresp_i != 2'b00) begin m_err = 1; m_errcnt++; end
      end
      if (awvalid_o && awready_i) begin
        aw_hs_cnt++;
        m_outst++;
        last_awaddr = awaddr_o;
        checks++;
        if (q.size() == 0 || m_aw_seen) begin errors++;
          $display("FAIL aw_unexpected awaddr=%h queued=%0d t=%0t", awaddr_o, q.size(), $time);
        end else if (awaddr_o !== ((q[0].addr >> OFF) << OFF)) begin errors++;
          $display("FAIL awaddr got %h exp %h t=%0t", awaddr_o, ((q[0].addr >> OFF) << OFF), $time);
        end
        m_aw_seen = 1;
      end
      if (wvalid_o && wready_i) begin
        w_hs_cnt++;
        if (wlast_o) wlast_cnt++;
        w_hist.push_back(wdata_o);
        checks++;
        if (q.size() == 0 || m_beat >= BEATS) begin errors++;
          $display("FAIL w_unexpected wdata=%h t=%0t", wdata_o, $time);
        end else begin
          exp_d = 64'(q[0].line >> (m_beat * DW));
          if (wdata_o !== exp_d || wlast_o !== (m_beat == BEATS - 1)) begin errors++;
            $display("FAIL wbeat%0d got %h/%b exp %h/%b t=%0t", m_beat, wdata_o, wlast_o, exp_d, (m_beat == BEATS - 1), $time);
          end
        end
        m_beat++;
      end
      pop_now = (q.size() != 0) && m_aw_seen && (m_beat == BEATS);
      if (pop_now) begin
        void'(q.pop_front());
        m_aw_seen = 0; m_beat = 0; pop_cnt++;
      end
      if (wren_i) begin
        if (q.size() < DEPTH) begin q.push_back(ent_t'(data_i)); push_cnt++; end
        else drop_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_rand) begin
      awready_i = 1'($urandom_range(0, 1));
      wready_i  = 1'($urandom_range(0, 1));
    end
    if (b_rand) begin
      bvalid_i = 1'($urandom_range(0, 1));
      bresp_i  = (b_err_rand && $urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
      bid_i    = 4'($urandom);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.addr = $urandom;
    for (int i = 0; i < LW / 32; i++) e.line[i*32 +: 32] = $urandom;
    return e;
  endfunction

  task automatic push(input ent_t e);
    wren_i = 1'b1; data_i = e;
    tick();
    wren_i = 1'b0;
  endtask

  task automatic set_mode(input bit rr, input bit aw, input bit w, input bit br, input bit be);
    rdy_rand = rr; b_rand = br; b_err_rand = be;
    awready_i = aw; wready_i = w;
    bvalid_i = 1'b0; bresp_i = 2'b00;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(idle_o === 1'b1 && q.size() == 0 && m_outst == 0) && n < budget) begin tick(); n++; end
    checks++;
    if (!(idle_o === 1'b1 && q.size() == 0 && m_outst == 0)) begin errors++;
      $display("FAIL %s_idle_timeout idle_o=%b queued=%0d outst=%0d after %0d cycles", tag, idle_o, q.size(), m_outst, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wren_i = 1'b0; data_i = '0; bid_i = '0;
    set_mode(0, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clk);
    checks++; if ({awvalid_o, wvalid_o, afull_o, err_o, idle_o, bready_o} !== 6'b000010) begin errors++;
      $display("FAIL reset_state aw/w/afull/err/idle/bready got %b exp 000010", {awvalid_o, wvalid_o, afull_o, err_o, idle_o, bready_o}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ent_t e;
    int aw0 = aw_hs_cnt, w0 = w_hs_cnt, l0 = wlast_cnt, h0 = w_hist.size();
    logic [DW-1:0] exp_b [4];
    exp_b[0] = 64'h1111_1111_1111_1111; exp_b[1] = 64'h2222_2222_2222_2222;
    exp_b[2] = 64'h3333_3333_3333_3333; exp_b[3] = 64'h4444_4444_4444_4444;
    e.addr = 32'h0000_1234;
    e.line = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    set_mode(0, 1, 1, 1, 0);
    push(e);
    wait_idle(100, "basic");
    checks++; if (aw_hs_cnt - aw0 != 1 || last_awaddr !== 32'h0000_1220) begin errors++;
      $display("FAIL basic_aw count=%0d awaddr=%h exp 1/00001220", aw_hs_cnt - aw0, last_awaddr); end
    checks++; if (w_hs_cnt - w0 != 4 || wlast_cnt - l0 != 1) begin errors++;
      $display("FAIL basic_w beats=%0d wlast=%0d exp 4/1", w_hs_cnt - w0, wlast_cnt - l0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (w_hist.size() < h0 + 4 || w_hist[h0 + k] !== exp_b[k]) begin errors++;
        $display("FAIL basic_beat%0d got %h exp %h", k, (w_hist.size() > h0 + k) ? w_hist[h0 + k] : 64'hx, exp_b[k]); end
    end
    checks++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin errors++;
      $display("FAIL basic_end idle=%b err=%b exp 1/0", idle_o, err_o); end
  endtask

  task automatic test_aw_stall();
    ent_t e = rand_ent();
    int w0 = w_hs_cnt, p0 = pop_cnt;
    set_mode(0, 0, 1, 0, 0);
    push(e);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      checks++; if (awvalid_o !== 1'b1 || awaddr_o !== ((e.addr >> OFF) << OFF)) begin errors++;
        $display("FAIL aw_stall_hold cyc%0d awvalid=%b awaddr=%h exp %h", i, awvalid_o, awaddr_o, ((e.addr >> OFF) << OFF)); end
    end
    tick();
    checks++; if (w_hs_cnt - w0 != 4 || pop_cnt != p0 || wvalid_o !== 1'b0) begin errors++;
      $display("FAIL aw_stall_wfirst beats=%0d pops=%0d wvalid=%b exp 4/0/0", w_hs_cnt - w0, pop_cnt - p0, wvalid_o); end
    awready_i = 1'b1; b_rand = 1;
    wait_idle(100, "aw_stall");
    checks++; if (pop_cnt - p0 != 1) begin errors++;
      $display("FAIL aw_stall_pop pops=%0d exp 1", pop_cnt - p0); end
  endtask

  task automatic test_outst();
    int a0 = aw_hs_cnt, p0 = pop_cnt;
    set_mode(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) push(rand_ent());
    repeat (60) tick();
    checks++; if (aw_hs_cnt - a0 != MAXO) begin errors++;
      $display("FAIL outst_limit aw=%0d exp %0d", aw_hs_cnt - a0, MAXO); end
    bvalid_i = 1'b1; bresp_i = 2'b00;
    tick();
    bvalid_i = 1'b0;
    repeat (20) tick();
    checks++; if (aw_hs_cnt - a0 != MAXO + 1) begin errors++;
      $display("FAIL outst_credit aw=%0d exp %0d", aw_hs_cnt - a0, MAXO + 1); end
    b_rand = 1;
    wait_idle(300, "outst");
    checks++; if (pop_cnt - p0 != 6) begin errors++;
      $display("FAIL outst_drain pops=%0d exp 6", pop_cnt - p0); end
  endtask

  task automatic test_fill();
    int p0 = pop_cnt, d0 = drop_cnt;
    set_mode(0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      push(rand_ent());
      if (k == 5) begin
        checks++; if (afull_o !== 1'b0) begin errors++; $display("FAIL fill_afull5 got %b exp 0", afull_o); end
      end
      if (k == 6) begin
        checks++; if (afull_o !== 1'b1) begin errors++; $display("FAIL fill_afull6 got %b exp 1", afull_o); end
      end
    end
    tick();
    checks++; if (drop_cnt - d0 != 1 || afull_o !== 1'b1) begin errors++;
      $display("FAIL fill_drop drops=%0d afull=%b exp 1/1", drop_cnt - d0, afull_o); end
    set_mode(0, 1, 1, 1, 0);
    wait_idle(400, "fill");
    checks++; if (pop_cnt - p0 != DEPTH) begin errors++;
      $display("FAIL fill_drain pops=%0d exp %0d", pop_cnt - p0, DEPTH); end
  endtask

  task automatic test_err();
    int n = 0;
    set_mode(0, 1, 1, 0, 0);
    push(rand_ent());
    while (bready_o !== 1'b1 && n < 40) begin tick(); n++; end
    bvalid_i = 1'b1; bresp_i = 2'b10;
    tick();
    bvalid_i = 1'b0; bresp_i = 2'b00;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
    push(rand_ent());
    push(rand_ent());
    b_rand = 1;
    wait_idle(200, "err");
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
`ifdef FILL_BURST_ERRCNT_EN
    checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL err_cnt got %0d exp 1", err_cnt_o); end
`endif
  endtask

  task automatic test_reset_mid();
    ent_t e1 = rand_ent();
    ent_t e2 = rand_ent();
    int w0 = w_hs_cnt, h0, n = 0;
    set_mode(0, 0, 1, 0, 0);
    push(e1);
    while (w_hs_cnt - w0 < 2 && n < 30) begin tick(); n++; end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({awvalid_o, wvalid_o, idle_o, afull_o, bready_o, err_o} !== 6'b001000) begin errors++;
      $display("FAIL rst_mid aw/w/idle/afull/bready/err got %b exp 001000", {awvalid_o, wvalid_o, idle_o, afull_o, bready_o, err_o}); end
    tick();
    rst = 1'b0;
    h0 = w_hist.size(); w0 = w_hs_cnt;
    awready_i = 1'b1; b_rand = 1;
    push(e2);
    wait_idle(100, "rst_mid");
    checks++; if (w_hs_cnt - w0 != 4 || w_hist.size() <= h0 || w_hist[h0] !== e2.line[DW-1:0]) begin errors++;
      $display("FAIL rst_mid_restart beats=%0d first=%h exp 4/%h", w_hs_cnt - w0, (w_hist.size() > h0) ? w_hist[h0] : 64'hx, e2.line[DW-1:0]); end
  endtask

  task automatic test_random();
    int p0 = pop_cnt, u0 = push_cnt;
    set_mode(1, 0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      if (afull_o === 1'b0 && $urandom_range(0, 2) == 0) push(rand_ent());
      else tick();
    end
    wait_idle(3000, "random");
    checks++; if (pop_cnt - p0 != push_cnt - u0 || push_cnt == u0) begin errors++;
      $display("FAIL random_drain pops=%0d pushes=%0d", pop_cnt - p0, push_cnt - u0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_stall();
    test_outst();
    test_fill();
    test_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fill_burst_writer.md
Name: fill_burst_writer

Overview:
Successor of the single-beat fill FIFO in the DRAM-cache write path. It buffers whole cache-line fill requests ({address, line data}) and drains each one to memory as an AXI INCR write burst of BEATS beats. The AW and W channels run independently, and outstanding B responses are tracked against a credit limit. It sits between the cache fill/evict logic and the AXI memory port.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data bus width (bits, multiple of 8)
BEATS, 4, beats per line; power of 2, 1..16
OFFSET_WIDTH, 5, line offset bits; must be >= log2(BEATS*DATA_WIDTH/8)
DEPTH, 8, line-entry FIFO depth; power of 2, >= 2
AFULL_MARGIN, 2, afull_o asserts when free entries <= AFULL_MARGIN
MAX_OUTST, 4, maximum AW bursts awaiting a B response; 1..15
ID_WIDTH, 4, AXI ID width
ID, 0, constant ID driven on awid_o and wid_o

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
afull_o  out  1  FIFO almost-full
wren_i  in  1  push request
data_i  in  ADDR_WIDTH+BEATS*DATA_WIDTH  {addr, line}; line occupies the low bits
idle_o  out  1  FIFO empty, FSM idle, and no outstanding bursts
awid_o  out  ID_WIDTH  write address ID
awaddr_o  out  ADDR_WIDTH  write address
awlen_o  out  4  burst length
awsize_o  out  3  beat size
awburst_o  out  2  burst type
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wid_o  out  ID_WIDTH  write data ID
wdata_o  out  DATA_WIDTH  write data
wstrb_o  out  DATA_WIDTH/8  write strobes
wlast_o  out  1  last beat
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bid_i  in  ID_WIDTH  response ID (ignored)
bresp_i  in  2  write response
bvalid_i  in  1  B valid
bready_o  out  1  B ready
err_o  out  1  sticky: non-OKAY response received

Behaviour:
- Single clock domain; rst is synchronous and active-high. Reset applies in every state, including mid-burst: the FIFO empties, the FSM goes to IDLE, counters clear, valids drop, err_o clears. Reset values: all valids 0, afull_o 0, err_o 0, idle_o 1, bready_o 0.
- Push:
  - Entry written when wren_i and the FIFO is not full.
  - wren_i while full is dropped; the upstream block must honour afull_o.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
- FSM states IDLE and SEND.
  - IDLE -> SEND when the FIFO is non-empty and outst < MAX_OUTST. Head entry loads into staging registers on that edge; awvalid_o and wvalid_o assert the next cycle.
  - SEND -> IDLE when AW is done and the last W beat has been accepted. The head pops on that edge; the next burst's valids appear no earlier than 2 cycles later.
- AW channel:
  - awaddr_o = {head addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH zeros}.
  - awlen_o = BEATS-1; awsize_o = log2(DATA_WIDTH/8); awburst_o = 2'b01 (INCR).
  - awvalid_o stays high until awready_i; then drops and the aw_done flag sets.
- W channel, independent of AW:
  - W may complete before, after, or in the same cycle as AW.
  - Beat k carries line[k*DATA_WIDTH +: DATA_WIDTH], beat 0 first.
  - Beat counter advances on wvalid_o & wready_i.
  - wlast_o = 1 exactly on beat BEATS-1; wstrb_o all ones.
  - Outputs hold stable while wvalid_o & !wready_i.
- Outstanding counter outst:
  - +1 on AW handshake; -1 on bvalid_i & bready_o; unchanged when both occur in one cycle.
  - bready_o = (outst != 0).
  - bvalid_i while outst == 0 is ignored and the counter does not underflow.
  - The MAX_OUTST check applies only at IDLE -> SEND.
- err_o sets on any accepted B with bresp_i != 2'b00; cleared only by reset.
- afull_o: registered from the FIFO count; asserts when DEPTH - count <= AFULL_MARGIN.
- idle_o = FIFO empty & FSM in IDLE & outst == 0.

Optional Feature:
- Macro FILL_BURST_ERRCNT_EN.
- Defined: adds output err_cnt_o, 8 bits.
  - Counts accepted B responses with bresp_i != 2'b00.
  - Saturates at 255; reset 0.
  - err_o behaviour unchanged.
- Undefined: the port and its counter are absent; everything else is identical.

Test Plan:
- Reset, then one push (addr 0x0000_1234, line beats 0x11..,0x22..,0x33..,0x44..), awready/wready tied 1 -> awaddr 0x0000_1220, awlen 3, 4 W beats in order, wlast only on beat 3, one B (OKAY) -> idle_o 1, err_o 0.
- Hold awready_i 0 for 10 cycles, wready_i 1 -> all 4 W beats complete first, awvalid held with stable awaddr; pop only after AW handshake.
- bvalid_i held 0, 6 entries pushed, MAX_OUTST 4 -> exactly 4 AW handshakes, then stall; one B returned -> a 5th burst issues.
- Push 8 entries back-to-back, no drain -> afull_o rises after the 6th push; a 9th push while full is dropped; drained count is exactly 8.
- B with bresp 2'b10 -> err_o sets and stays 1 through later OKAY responses; with FILL_BURST_ERRCNT_EN, err_cnt_o = 1.
- Assert rst mid-burst (after beat 1) -> next cycle all valids 0, idle_o 1, FIFO empty; a new push then issues from beat 0.
